// File: rtl/soin_arb_pkg.sv
// Shared types and default parameters for the IF/LS memory port arbiter.
package soin_arb_pkg;

  localparam int DEF_MEM_LAT  = 1;
  localparam int DEF_MAX_WAIT = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } owner_slot_t;

endpackage

// File: rtl/arb_owner_pipe.sv
// MEM_LAT-deep shift register tracking which requester owns each in-flight read.
module arb_owner_pipe
  import soin_arb_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  owner_slot_t i_slot,
  output owner_slot_t o_slot
);

  owner_slot_t [MEM_LAT-1:0] slot_q;
  owner_slot_t [MEM_LAT-1:0] slot_d;

  always_comb begin
    slot_d    = slot_q;
    slot_d[0] = i_slot;
    for (int i = 1; i < MEM_LAT; i++) begin
      slot_d[i] = slot_q[i-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign o_slot = slot_q[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined memory port between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration instead of LS priority with starvation guard.
module mem_port_arbiter
  import soin_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [DATA_W/8-1:0] i_ls_be,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  logic        if_win;
  logic        ls_win;
  logic        if_prio;
  owner_slot_t slot_in;
  owner_slot_t slot_out;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q;
  owner_e last_d;

  assign if_prio = (last_q == OWN_LS);

  always_comb begin
    last_d = last_q;
    if (if_win) begin
      last_d = OWN_IF;
    end else if (ls_win) begin
      last_d = OWN_LS;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q <= OWN_IF;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam int SW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;

  assign if_prio = (starve_q == STARVE_MAX);

  always_comb begin
    starve_d = starve_q;
    if (!i_if_req || if_win) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Grants are masked while reset is held so nothing reaches the memory.
  assign if_win = !i_rst && i_if_req && (!i_ls_req || if_prio);
  assign ls_win = !i_rst && i_ls_req && !if_win;

  assign o_if_gnt = if_win;
  assign o_ls_gnt = ls_win;

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (if_win) begin
      o_mem_req  = 1'b1;
      o_mem_be   = '1;
      o_mem_addr = i_if_addr;
    end else if (ls_win) begin
      o_mem_req   = 1'b1;
      o_mem_we    = i_ls_we;
      o_mem_be    = i_ls_be;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
    end
  end

  always_comb begin
    slot_in.valid = if_win || (ls_win && !i_ls_we);
    slot_in.owner = ls_win ? OWN_LS : OWN_IF;
  end

  arb_owner_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_owner_pipe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_slot (slot_in),
    .o_slot (slot_out)
  );

  assign o_if_rvalid = slot_out.valid && (slot_out.owner == OWN_IF);
  assign o_ls_rvalid = slot_out.valid && (slot_out.owner == OWN_LS);
  assign o_if_rdata  = i_mem_rdata;
  assign o_ls_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3 share stimulus.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;

  logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_mem_req, a_mem_we;
  logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_be;
  logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_req, b_mem_we;
  logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(4)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(a_if_gnt), .o_if_rvalid(a_if_rvalid), .o_if_rdata(a_if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_be(ls_be), .i_ls_addr(ls_addr),
    .i_ls_wdata(ls_wdata),
    .o_ls_gnt(a_ls_gnt), .o_ls_rvalid(a_ls_rvalid), .o_ls_rdata(a_ls_rdata),
    .o_mem_req(a_mem_req), .o_mem_we(a_mem_we), .o_mem_be(a_mem_be),
    .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_WAIT(4)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(b_if_gnt), .o_if_rvalid(b_if_rvalid), .o_if_rdata(b_if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_be(ls_be), .i_ls_addr(ls_addr),
    .i_ls_wdata(ls_wdata),
    .o_ls_gnt(b_ls_gnt), .o_ls_rvalid(b_ls_rvalid), .o_ls_rdata(b_ls_rdata),
    .o_mem_req(b_mem_req), .o_mem_we(b_mem_we), .o_mem_be(b_mem_be),
    .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata)
  );

  // Environment memory, driven only by dut_a's port; dut_b reads the same contents.
  logic [31:0] env_mem [0:1023];
  logic [31:0] rd_a;
  logic [31:0] rd_b [0:2];

  always @(posedge clk) begin
    if (a_mem_req && a_mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (a_mem_be[k]) env_mem[a_mem_addr[11:2]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
      end
    end
    rd_a    <= (a_mem_req && !a_mem_we) ? env_mem[a_mem_addr[11:2]] : 32'h0BAD_0BAD;
    rd_b[0] <= (b_mem_req && !b_mem_we) ? env_mem[b_mem_addr[11:2]] : 32'h0BAD_0BAD;
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end

  assign a_mem_rdata = rd_a;
  assign b_mem_rdata = rd_b[2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and response scoreboard
  typedef struct {
    bit          owner;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       qa[$];
  resp_t       qb[$];
  logic [31:0] gold_mem [0:1023];
  int          starve  = 0;
  bit          last_ls = 1'b0;

  task automatic sb(input bit inst_b, input logic ifv, input logic lsv,
                    input logic [31:0] ifd, input logic [31:0] lsd);
    resp_t f;
    bit    have;
    have = inst_b ? (qb.size() > 0) : (qa.size() > 0);
    if (have) f = inst_b ? qb[0] : qa[0];
    if (rst) begin
      check(inst_b ? "b_rst_if_rvalid" : "a_rst_if_rvalid", ifv, 1'b0);
      check(inst_b ? "b_rst_ls_rvalid" : "a_rst_ls_rvalid", lsv, 1'b0);
    end else if (have && f.due == cyc) begin
      if (inst_b) void'(qb.pop_front());
      else        void'(qa.pop_front());
      check(inst_b ? "b_sb_if_rvalid" : "a_sb_if_rvalid", ifv, !f.owner);
      check(inst_b ? "b_sb_ls_rvalid" : "a_sb_ls_rvalid", lsv, f.owner);
      check(inst_b ? "b_sb_rdata" : "a_sb_rdata", f.owner ? lsd : ifd, f.data);
    end else begin
      check(inst_b ? "b_idle_if_rvalid" : "a_idle_if_rvalid", ifv, 1'b0);
      check(inst_b ? "b_idle_ls_rvalid" : "a_idle_ls_rvalid", lsv, 1'b0);
    end
  endtask

  task automatic monitor_step();
    logic        prio, e_if, e_ls, e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    resp_t       r;
`ifdef ARB_ROUND_ROBIN_EN
    prio = last_ls;
`else
    prio = (starve == 4);
`endif
    e_if   = !rst && if_req && (!ls_req || prio);
    e_ls   = !rst && ls_req && !e_if;
    e_req  = e_if || e_ls;
    e_we   = e_ls && ls_we;
    e_be   = e_if ? 4'hF : (e_ls ? ls_be : 4'h0);
    e_addr = e_if ? if_addr : (e_ls ? ls_addr : 32'h0);
    e_wd   = e_ls ? ls_wdata : 32'h0;

    check("a_if_gnt", a_if_gnt, e_if);
    check("a_ls_gnt", a_ls_gnt, e_ls);
    check("b_if_gnt", b_if_gnt, e_if);
    check("b_ls_gnt", b_ls_gnt, e_ls);
    check("a_mem_req", a_mem_req, e_req);
    check("a_mem_we", a_mem_we, e_we);
    check("a_mem_be", a_mem_be, e_be);
    check("a_mem_addr", a_mem_addr, e_addr);
    check("b_mem_req", b_mem_req, e_req);
    check("b_mem_addr", b_mem_addr, e_addr);
    if (!e_if) check("a_mem_wdata", a_mem_wdata, e_wd);

    sb(1'b0, a_if_rvalid, a_ls_rvalid, a_if_rdata, a_ls_rdata);
    sb(1'b1, b_if_rvalid, b_ls_rvalid, b_if_rdata, b_ls_rdata);

    if (rst) begin
      starve  = 0;
      last_ls = 1'b0;
      qa.delete();
      qb.delete();
    end else begin
      if (e_if || (e_ls && !ls_we)) begin
        r.owner = e_ls;
        r.data  = gold_mem[e_addr[11:2]];
        r.due   = cyc + 1;
        qa.push_back(r);
        r.due   = cyc + 3;
        qb.push_back(r);
      end
      if (e_we) begin
        for (int k = 0; k < 4; k++) begin
          if (ls_be[k]) gold_mem[ls_addr[11:2]][8*k +: 8] = ls_wdata[8*k +: 8];
        end
      end
      if (!if_req || e_if) starve = 0;
      else if (starve < 4) starve++;
      if (e_if) last_ls = 1'b0;
      else if (e_ls) last_ls = 1'b1;
    end
    cyc++;
  endtask

  always @(negedge clk) monitor_step();

  // Stimulus tables
  typedef struct {
    logic rst, ir;
    logic [31:0] ia;
    logic lr, lw;
    logic [3:0] lbe;
    logic [31:0] la, lwd;
    logic e_ig, e_lg, e_irv, e_lrv;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    logic rst, ir;
    logic [31:0] ia;
    logic lr;
    logic [31:0] la;
    logic e_aif, e_als, e_bif, e_bls;
  } seq_t;

  vec_t tbl [18];
  seq_t sq  [13];

  task automatic row(input int i, input logic rs, input logic ir, input logic [31:0] ia,
                     input logic lr, input logic lw, input logic [3:0] lbe,
                     input logic [31:0] la, input logic [31:0] lwd,
                     input logic ig, input logic lg, input logic irv, input logic lrv,
                     input logic [31:0] rd);
    tbl[i].rst = rs;  tbl[i].ir = ir;   tbl[i].ia = ia;   tbl[i].lr = lr;
    tbl[i].lw = lw;   tbl[i].lbe = lbe; tbl[i].la = la;   tbl[i].lwd = lwd;
    tbl[i].e_ig = ig; tbl[i].e_lg = lg; tbl[i].e_irv = irv; tbl[i].e_lrv = lrv;
    tbl[i].e_rd = rd;
  endtask

  task automatic srow(input int i, input logic rs, input logic ir, input logic [31:0] ia,
                      input logic lr, input logic [31:0] la,
                      input logic aif, input logic als, input logic bif, input logic bls);
    sq[i].rst = rs; sq[i].ir = ir; sq[i].ia = ia; sq[i].lr = lr; sq[i].la = la;
    sq[i].e_aif = aif; sq[i].e_als = als; sq[i].e_bif = bif; sq[i].e_bls = bls;
  endtask

  task automatic drive(input logic rs, input logic ir, input logic [31:0] ia, input logic lr,
                       input logic lw, input logic [3:0] lbe, input logic [31:0] la,
                       input logic [31:0] lwd);
    rst = rs; if_req = ir; if_addr = ia; ls_req = lr;
    ls_we = lw; ls_be = lbe; ls_addr = la; ls_wdata = lwd;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      env_mem[i]  <= 32'hA500_0000 | i;
      gold_mem[i]  = 32'hA500_0000 | i;
    end
    env_mem[16]  <= 32'h1122_3344;
    gold_mem[16]  = 32'h1122_3344;

    //        rst ir ia     lr lw be    la     wdata         ig lg irv lrv rdata
    row( 0, 1, 1, 32'h10, 1, 0, 4'hF, 32'h200, 32'h0,        0, 0, 0, 0, 32'h0);
    row( 1, 0, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0);
    row( 2, 0, 1, 32'h10, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 0, 0, 32'h0);
    row( 3, 0, 1, 32'h14, 1, 0, 4'hF, 32'h200, 32'h0,        0, 1, 1, 0, 32'hA500_0004);
    row( 4, 0, 1, 32'h14, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 0, 1, 32'hA500_0080);
    row( 5, 0, 0, 32'h0,  1, 1, 4'h3, 32'h40,  32'hDEADBEEF, 0, 1, 1, 0, 32'hA500_0005);
    row( 6, 0, 0, 32'h0,  1, 0, 4'hF, 32'h40,  32'h0,        0, 1, 0, 0, 32'h0);
    row( 7, 0, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 1, 32'h1122_BEEF);
    row( 8, 0, 1, 32'h14, 1, 0, 4'hF, 32'h200, 32'h0,        0, 1, 0, 0, 32'h0);
    row( 9, 0, 1, 32'h14, 1, 0, 4'hF, 32'h200, 32'h0,        0, 1, 0, 1, 32'hA500_0080);
    row(10, 0, 1, 32'h14, 1, 0, 4'hF, 32'h200, 32'h0,        0, 1, 0, 1, 32'hA500_0080);
    row(11, 0, 1, 32'h14, 1, 0, 4'hF, 32'h200, 32'h0,        0, 1, 0, 1, 32'hA500_0080);
    row(12, 0, 1, 32'h14, 1, 0, 4'hF, 32'h200, 32'h0,        1, 0, 0, 1, 32'hA500_0080);
    row(13, 0, 1, 32'h14, 1, 0, 4'hF, 32'h200, 32'h0,        0, 1, 1, 0, 32'hA500_0005);
    row(14, 0, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 1, 32'hA500_0080);
    row(15, 0, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0);
    row(16, 0, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0);
    row(17, 0, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0);

    //         rst ir ia     lr la       a_if a_ls b_if b_ls
    srow( 0, 0, 1, 32'h10, 0, 32'h0,   0, 0, 0, 0);
    srow( 1, 0, 0, 32'h0,  1, 32'h200, 1, 0, 0, 0);
    srow( 2, 0, 1, 32'h14, 0, 32'h0,   0, 1, 0, 0);
    srow( 3, 0, 0, 32'h0,  0, 32'h0,   1, 0, 1, 0);
    srow( 4, 0, 0, 32'h0,  0, 32'h0,   0, 0, 0, 1);
    srow( 5, 0, 0, 32'h0,  0, 32'h0,   0, 0, 1, 0);
    srow( 6, 0, 1, 32'h10, 0, 32'h0,   0, 0, 0, 0);
    srow( 7, 1, 1, 32'h10, 0, 32'h0,   0, 0, 0, 0);
    for (int i = 8; i < 13; i++) srow(i, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      drive(tbl[i].rst, tbl[i].ir, tbl[i].ia, tbl[i].lr, tbl[i].lw, tbl[i].lbe,
            tbl[i].la, tbl[i].lwd);
      @(negedge clk);
      #1;
`ifndef ARB_ROUND_ROBIN_EN
      check("tbl_if_gnt", a_if_gnt, tbl[i].e_ig);
      check("tbl_ls_gnt", a_ls_gnt, tbl[i].e_lg);
      check("tbl_if_rvalid", a_if_rvalid, tbl[i].e_irv);
      check("tbl_ls_rvalid", a_ls_rvalid, tbl[i].e_lrv);
      if (tbl[i].e_irv) check("tbl_if_rdata", a_if_rdata, tbl[i].e_rd);
      if (tbl[i].e_lrv) check("tbl_ls_rdata", a_ls_rdata, tbl[i].e_rd);
`endif
    end

    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      drive(sq[i].rst, sq[i].ir, sq[i].ia, sq[i].lr, 1'b0, 4'hF, sq[i].la, 32'h0);
      @(negedge clk);
      #1;
      check("seq_a_if_rvalid", a_if_rvalid, sq[i].e_aif);
      check("seq_a_ls_rvalid", a_ls_rvalid, sq[i].e_als);
      check("seq_b_if_rvalid", b_if_rvalid, sq[i].e_bif);
      check("seq_b_ls_rvalid", b_ls_rvalid, sq[i].e_bls);
    end

`ifdef ARB_ROUND_ROBIN_EN
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, 32'h20 + 32'(4 * i), 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
      @(negedge clk);
      #1;
      check("rr_ls_gnt", a_ls_gnt, (i % 2) == 0);
      check("rr_if_gnt", a_if_gnt, (i % 2) == 1);
    end
`endif

    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    check("sb_a_drained", 32'(qa.size()), 32'd0);
    check("sb_b_drained", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
